// File: rtl/div_iter_pkg.sv
// Shared M-extension divider definitions: op and state encodings plus constants.
package div_iter_pkg;

   // Bit 0 selects unsigned, bit 1 selects remainder
   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } div_state_t;

   localparam int          DIV_ITERS     = 32;
   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_iter_step.sv
// One restoring radix-2 division step, purely combinational.
module div_step #(
   parameter int W = 32
) (
   input  logic [W:0]   rem_i,
   input  logic [W-1:0] divisor_i,
   input  logic         dividend_bit_i,
   output logic [W:0]   rem_o,
   output logic         q_bit_o
);

   logic [W+1:0] shifted;
   logic [W+1:0] diff;

   // Shift in the next dividend bit, trial-subtract, restore on borrow
   always_comb begin
      shifted = {rem_i, dividend_bit_i};
      diff    = shifted - {2'b00, divisor_i};
      q_bit_o = ~diff[W+1];
      rem_o   = diff[W+1] ? shifted[W:0] : diff[W:0];
   end

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// The dividend magnitude is shifted out of quo_q MSB-first while quotient
// bits shift in at the LSB, so one register serves both roles.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            kill,
   input  logic [1:0]      div_op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            ready,
   output logic            busy,
   output logic            result_vld,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(DIV_ITERS);

   div_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvsr_q, dvsr_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic            rem_sel_q, rem_sel_d;
   logic [XLEN-1:0] result_q, result_d;

   logic [XLEN:0]   step_rem;
   logic            step_qbit;
   logic            is_signed;
   logic            ovf;

   div_step #(.W(XLEN)) u_step (
      .rem_i          (rem_q),
      .divisor_i      (dvsr_q),
      .dividend_bit_i (quo_q[XLEN-1]),
      .rem_o          (step_rem),
      .q_bit_o        (step_qbit)
   );

   assign is_signed = ~div_op[0];
   assign ovf       = is_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

   // Next-state and datapath update; kill overrides everything below
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      rem_sel_d = rem_sel_q;
      result_d  = result_q;
      case (state_q)
         IDLE: begin
            if (start && !kill) begin
               if (rs2 == '0) begin
                  // Divide by zero: all-ones quotient, dividend as remainder
                  result_d = div_op[1] ? rs1 : DIV_BY_ZERO_Q;
                  state_d  = DONE;
               end else if (ovf) begin
                  result_d = div_op[1] ? '0 : rs1;
                  state_d  = DONE;
               end else begin
                  quo_d     = (is_signed && rs1[XLEN-1]) ? -rs1 : rs1;
                  dvsr_d    = (is_signed && rs2[XLEN-1]) ? -rs2 : rs2;
                  rem_d     = '0;
                  qneg_d    = is_signed & (rs1[XLEN-1] ^ rs2[XLEN-1]);
                  rneg_d    = is_signed & rs1[XLEN-1];
                  rem_sel_d = div_op[1];
                  cnt_d     = CNT_W'(DIV_ITERS - 1);
                  state_d   = CALC;
               end
            end
         end
         CALC: begin
            rem_d = step_rem;
            quo_d = {quo_q[XLEN-2:0], step_qbit};
            if (cnt_q == '0) state_d = FIX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         FIX: begin
            if (rem_sel_q) result_d = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
            else           result_d = qneg_q ? -quo_q : quo_q;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (kill) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         rem_sel_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         rem_sel_q <= rem_sel_d;
         result_q  <= result_d;
      end
   end

   assign ready      = (state_q == IDLE);
   assign busy       = (state_q == CALC) || (state_q == FIX);
   assign result_vld = (state_q == DONE);
   assign result     = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: stimulus pushes expected result and arrival
// cycle; a negedge monitor pops and compares on every result_vld.
module tb_div_iter;
   import div_iter_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, kill;
   logic [1:0]  div_op;
   logic [31:0] rs1, rs2;
   logic        ready, busy, result_vld;
   logic [31:0] result;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [31:0] last_exp = '0;

   div_iter #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .div_op(div_op),
      .rs1(rs1), .rs2(rs2), .ready(ready), .busy(busy),
      .result_vld(result_vld), .result(result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every result pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && result_vld) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_vld result=%h cyc=%0d", result, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (result !== e.res || cyc != e.cyc) begin
               failures++;
               $display("FAIL %s result=%h exp=%h cyc=%0d exp_cyc=%0d",
                        e.name, result, e.res, cyc, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Called right after a negedge; returns at the negedge following acceptance.
   // lat is the spec latency: 34 normal, 1 for special cases.
   task automatic start_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat, input string nm,
                           input bit push);
      exp_t e;
      chk({nm, "_ready"}, {31'd0, ready}, 32'd1);
      if (push) begin
         e.res = exp; e.cyc = cyc + lat; e.name = nm;
         sb.push_back(e);
         last_exp = exp;
      end
      div_op = op; rs1 = a; rs2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_timeout ready=%b exp=1", nm, ready);
      end
   endtask

   task automatic run(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, input string nm);
      start_op(op, a, b, exp, lat, nm, 1'b1);
      wait_idle(nm);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; kill = 1'b0; div_op = 2'b00; rs1 = '0; rs2 = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_vld", {31'd0, result_vld}, 32'd0);
      chk("rst_result", result, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Normal-path arithmetic
      run(DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
      run(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
      run(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
      run(DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2");
      run(REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34, "rem_7_m2");
      run(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, "divu_max_1");
      run(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, "divu_nooverflow");
      run(REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "remu_nooverflow");

      // Special cases: single-cycle turnaround
      run(DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, "div_by_zero");
      run(REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1, "rem_by_zero");
      run(DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, "divu_by_zero");
      run(REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, "rem_neg_by_zero");
      run(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_overflow");
      run(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_overflow");

      // START while busy is ignored and operands are not re-sampled
      start_op(REMU, 32'd100, 32'd7, 32'd2, 34, "remu_100_7", 1'b1);
      repeat (5) @(negedge clk);
      div_op = DIVU; rs1 = 32'd5; rs2 = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_mid_calc", {31'd0, busy}, 32'd1);
      wait_idle("remu_100_7");

      // KILL mid-CALC, then restart in the very next cycle
      start_op(DIVU, 32'd1000, 32'd3, 32'd333, 34, "killed", 1'b0);
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_ready", {31'd0, ready}, 32'd1);
      chk("kill_busy", {31'd0, busy}, 32'd0);
      chk("kill_hold", result, last_exp);
      run(DIVU, 32'd100, 32'd7, 32'd14, 34, "after_kill");

      // KILL and START together in IDLE: nothing accepted
      div_op = DIVU; rs1 = 32'd9; rs2 = 32'd3; start = 1'b1; kill = 1'b1;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      chk("kill_start_ready", {31'd0, ready}, 32'd1);
      chk("kill_start_hold", result, 32'd14);

      // KILL during DONE: the pulse already up stays up
      start_op(DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, "kill_in_done", 1'b1);
      #1 kill = 1'b1;
      #1 chk("kill_done_vld", {31'd0, result_vld}, 32'd1);
      @(negedge clk);
      kill = 1'b0;
      chk("kill_done_ready", {31'd0, ready}, 32'd1);

      // Reset mid-CALC discards the operation
      start_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "reset_mid", 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst2_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst2_ready", {31'd0, ready}, 32'd1);
      chk("rst2_result", result, 32'd0);
      repeat (40) @(negedge clk);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL missing_results outstanding=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
